// File: rtl/gpu_regfile_pkg.sv
// Shared definitions for the double-buffered GPU register file: register map,
// CTRL bit positions, commit FSM states and the CTRL read-word builder.
package gpu_regfile_pkg;

  // Word addresses; vertex slots start at REG_VERTEX0, colour slots follow them
  localparam int unsigned REG_CTRL        = 0;
  localparam int unsigned REG_BACK_COLOUR = 1;
  localparam int unsigned REG_WIN_SIZE    = 2;
  localparam int unsigned REG_VERTEX0     = 3;

  // CTRL bit positions
  localparam int unsigned CTRL_GO         = 0;
  localparam int unsigned CTRL_PENDING    = 1;
  localparam int unsigned CTRL_BUSY       = 2;
  localparam int unsigned CTRL_DONE       = 3;
  localparam int unsigned CTRL_IRQ_EN     = 4;
  localparam int unsigned CTRL_STATUS_LSB = 32;
  localparam int unsigned STATUS_W        = 32;
  localparam int unsigned CTRL_W          = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_COPY = 2'd2
  } commit_state_e;

  // Assemble the CTRL read value; unlisted bits read as zero
  function automatic logic [CTRL_W-1:0] ctrl_word(
    input logic [STATUS_W-1:0] status,
    input logic                irq_en,
    input logic                done,
    input logic                busy,
    input logic                pending
  );
    logic [CTRL_W-1:0] w;
    w                                = '0;
    w[CTRL_STATUS_LSB +: STATUS_W]   = status;
    w[CTRL_IRQ_EN]                   = irq_en;
    w[CTRL_DONE]                     = done;
    w[CTRL_BUSY]                     = busy;
    w[CTRL_PENDING]                  = pending;
    return w;
  endfunction

endpackage

// File: rtl/gpu_reg_bemerge.sv
// Byte-enable merge of one register word: each enabled byte lane takes the
// write data, the others keep the old value.
//   old_i    : current register contents
//   wdata_i  : bus write data
//   be_i     : byte lane enables, lane 0 = bits [7:0]
//   merged_c : merged word (combinational)
module gpu_reg_bemerge #(
  parameter int unsigned DATA_W = 64
) (
  input  logic [DATA_W-1:0]   old_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] be_i,
  output logic [DATA_W-1:0]   merged_c
);

  localparam int unsigned BE_W = DATA_W / 8;

  for (genvar b = 0; b < BE_W; b++) begin : g_lane
    assign merged_c[8*b +: 8] = be_i[b] ? wdata_i[8*b +: 8] : old_i[8*b +: 8];
  end

endmodule

// File: rtl/gpu_regfile_dbuf.sv
// Double-buffered GPU register file on an Avalon-MM slave. The HPS stages a
// shadow bank; writing GO commits it atomically into the active bank that
// feeds the rasteriser, deferred until the rasteriser is idle.
//   clk, reset_n           : clock, async active-low reset
//   avs_*                  : Avalon-MM slave (1-cycle registered reads)
//   vertex_o, colour_o     : active vertex/colour slots, slot 0 in LSBs
//   back_colour_o          : active background colour
//   win_size_o             : active window size
//   start_o                : 1-cycle pulse after the active bank updates
//   busy_i, done_i         : rasteriser busy level / render-complete pulse
//   status_load_i/status_in: FPGA status word into CTRL[63:32]
//   irq_o                  : level interrupt, DONE & IRQ_EN
module gpu_regfile_dbuf
  import gpu_regfile_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned NUM_VERTS = 3,
  parameter int unsigned ADDR_W    = $clog2(3 + 2 * NUM_VERTS)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [ADDR_W-1:0]             avs_address,
  input  logic                          avs_read,
  input  logic                          avs_write,
  input  logic [DATA_W-1:0]             avs_writedata,
  input  logic [DATA_W/8-1:0]           avs_byteenable,
  output logic [DATA_W-1:0]             avs_readdata,
  output logic                          avs_readdatavalid,
  output logic                          avs_waitrequest,
  output logic [NUM_VERTS*DATA_W-1:0]   vertex_o,
  output logic [NUM_VERTS*DATA_W-1:0]   colour_o,
  output logic [DATA_W-1:0]             back_colour_o,
  output logic [DATA_W-1:0]             win_size_o,
  output logic                          start_o,
  input  logic                          busy_i,
  input  logic                          done_i,
  input  logic                          status_load_i,
  input  logic [STATUS_W-1:0]           status_in,
  output logic                          irq_o
);

  localparam int unsigned NUM_REGS = 3 + 2 * NUM_VERTS;
  // Data registers occupy addresses 1..NUM_REGS-1; array index = address - 1
  localparam int unsigned NUM_DATA = NUM_REGS - 1;

  commit_state_e         state_q, state_d;
  logic                  start_q, start_d;
  logic                  done_q, done_d;
  logic                  irq_en_q, irq_en_d;
  logic                  irq_q, irq_d;
  logic [STATUS_W-1:0]   status_q, status_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;

  logic                  ctrl_sel_c;
  logic                  wr_acc_c;
  logic                  ctrl_wr_c;
  logic                  go_c;
  logic                  copy_c;
  logic [DATA_W-1:0]     rd_mux_c;

  logic [DATA_W-1:0]     shadow_vec [NUM_DATA];
  logic [DATA_W-1:0]     active_vec [NUM_DATA];

  // Bus handshake: only shadow-register writes stall, and only mid-commit
  assign ctrl_sel_c      = (avs_address == ADDR_W'(REG_CTRL));
  assign avs_waitrequest = avs_write && !ctrl_sel_c && (state_q != ST_IDLE);
  assign wr_acc_c        = avs_write && !avs_waitrequest;
  assign ctrl_wr_c       = wr_acc_c && ctrl_sel_c && avs_byteenable[0];
  assign go_c            = ctrl_wr_c && avs_writedata[CTRL_GO];

  // Commit FSM next state; copy happens in COPY, start pulses the cycle after
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    copy_c  = 1'b0;
    unique case (state_q)
      ST_IDLE: if (go_c) state_d = ST_PEND;
      ST_PEND: if (!busy_i) state_d = ST_COPY;
      ST_COPY: begin
        copy_c  = 1'b1;
        start_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // CTRL: done_i set takes priority over a same-cycle W1C
  always_comb begin
    done_d   = done_q;
    irq_en_d = irq_en_q;
    status_d = status_q;
    if (ctrl_wr_c) begin
      irq_en_d = avs_writedata[CTRL_IRQ_EN];
      if (avs_writedata[CTRL_DONE]) done_d = 1'b0;
    end
    if (done_i) done_d = 1'b1;
    if (status_load_i) status_d = status_in;
    irq_d = done_d && irq_en_d;
  end

  // Read mux over CTRL and the shadow bank; unmapped addresses read zero
  always_comb begin
    rd_mux_c = '0;
    if (ctrl_sel_c) begin
      rd_mux_c = DATA_W'(ctrl_word(status_q, irq_en_q, done_q, busy_i,
                                   state_q != ST_IDLE));
    end
    for (int k = 0; k < int'(NUM_DATA); k++) begin
      if (avs_address == ADDR_W'(k + 1)) rd_mux_c = shadow_vec[k];
    end
    rvalid_d = avs_read;
    rdata_d  = avs_read ? rd_mux_c : rdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      status_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      done_q   <= done_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      status_q <= status_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Shadow/active bank pair per data register
  for (genvar k = 0; k < NUM_DATA; k++) begin : g_bank
    logic [DATA_W-1:0] merged_c;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [DATA_W-1:0] active_q, active_d;

    gpu_reg_bemerge #(
      .DATA_W (DATA_W)
    ) u_bemerge (
      .old_i    (shadow_q),
      .wdata_i  (avs_writedata),
      .be_i     (avs_byteenable),
      .merged_c (merged_c)
    );

    always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      if (wr_acc_c && (avs_address == ADDR_W'(k + 1))) shadow_d = merged_c;
      if (copy_c) active_d = shadow_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        shadow_q <= '0;
        active_q <= '0;
      end else begin
        shadow_q <= shadow_d;
        active_q <= active_d;
      end
    end

    assign shadow_vec[k] = shadow_q;
    assign active_vec[k] = active_q;
  end

  // Active bank onto the rasteriser-facing ports
  for (genvar i = 0; i < NUM_VERTS; i++) begin : g_out
    assign vertex_o[i*DATA_W +: DATA_W] = active_vec[REG_VERTEX0 - 1 + i];
    assign colour_o[i*DATA_W +: DATA_W] = active_vec[REG_VERTEX0 - 1 + NUM_VERTS + i];
  end

  assign back_colour_o     = active_vec[REG_BACK_COLOUR - 1];
  assign win_size_o        = active_vec[REG_WIN_SIZE - 1];
  assign start_o           = start_q;
  assign irq_o             = irq_q;
  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;

endmodule
